// File: rtl/mono_scanout.sv
// mono_scanout
// Stores dithered 16-pixel words into a 1bpp framebuffer and scans it out
// continuously as a serial monochrome video stream with hsync/vsync.
// The framebuffer decouples the source frame timing from the CRT timing.
//
// Pipeline: during the cycle where hCount_q/vCount_q point at pixel (h,v),
// the pixel is selected combinationally and registered, so it appears on
// the outputs one cycle later together with the matching sync/active bits.
// The RAM read is registered, so each word is requested on the last pixel
// of the preceding group (or the last clk of the preceding line for word 0)
// and consumed straight from the RAM output register on the group's first
// pixel, then held in curWord_q for the remaining fifteen.

module mono_scanout #(
    parameter int WIDTH        = 512,
    parameter int HEIGHT       = 342,
    parameter int H_TOTAL      = 704,
    parameter int H_SYNC_START = 526,
    parameter int H_SYNC_LEN   = 178,
    parameter int V_TOTAL      = 370,
    parameter int V_SYNC_START = 342,
    parameter int V_SYNC_LEN   = 4,
    parameter bit INVERT       = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in_bits,
    input  logic [11:0] in_xaddr,
    input  logic [11:0] in_yaddr,
    input  logic        in_valid,
    input  logic        in_vsync,
    output logic        video,
    output logic        hsync_n,
    output logic        vsync_n,
    output logic        active
);

    localparam int WORDS  = WIDTH / 16;
    localparam int DEPTH  = WORDS * HEIGHT;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int HW     = $clog2(H_TOTAL);
    localparam int VW     = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT        = HW'(WIDTH);
    localparam logic [HW-1:0] H_LAST_FETCH = HW'(WIDTH - 16);
    localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT        = VW'(HEIGHT);

    localparam logic [HW:0] HS_BEGIN = (HW + 1)'(H_SYNC_START);
    localparam logic [HW:0] HS_END   = (HW + 1)'(H_SYNC_START + H_SYNC_LEN);
    localparam logic [VW:0] VS_BEGIN = (VW + 1)'(V_SYNC_START);
    localparam logic [VW:0] VS_END   = (VW + 1)'(V_SYNC_START + V_SYNC_LEN);

    localparam logic [11:0] X_LIMIT = 12'(WIDTH);
    localparam logic [11:0] Y_LIMIT = 12'(HEIGHT);

    // Linear word index of (line, group); callers guarantee both are in range.
    function automatic logic [ADDR_W-1:0] wordAddr(input logic [11:0] line,
                                                   input logic [7:0]  group);
        return ADDR_W'(line) * ADDR_W'(WORDS) + ADDR_W'(group);
    endfunction

    // Scan position and sticky "source has started" flag.
    logic [HW-1:0] hCount_q, hCount_d;
    logic [VW-1:0] vCount_q, vCount_d;
    logic          armed_q, armed_d;

    // Word currently being serialised (pixels 1..15 of a group).
    logic [15:0]   curWord_q, curWord_d;

    // Registered outputs.
    logic          video_q, video_d;
    logic          hsyncN_q, hsyncN_d;
    logic          vsyncN_q, vsyncN_d;
    logic          active_q, active_d;

    // Framebuffer and its ports.
    logic [15:0]       fbMem [DEPTH];
    logic [15:0]       ramRd_q;
    logic [ADDR_W-1:0] rdAddr;
    logic [ADDR_W-1:0] wrAddr;
    logic              wrEn;

    logic [VW-1:0] vNext;
    logic          inActive;
    logic          lineActive;
    logic [15:0]   pixWord;
    logic          pixBit;
    logic          unusedBits;

    // Sub-word x bits only position pixels inside a word, never the word itself.
    assign unusedBits = ^in_xaddr[3:0];

    assign vNext      = (vCount_q == V_LAST) ? '0 : vCount_q + 1'b1;
    assign lineActive = (vCount_q < V_ACT);
    assign inActive   = lineActive && (hCount_q < H_ACT);

    // Out-of-range words (including the 0xFFx wrap addresses) are dropped.
    assign wrEn   = in_valid && (in_xaddr < X_LIMIT) && (in_yaddr < Y_LIMIT);
    assign wrAddr = wordAddr(in_yaddr, in_xaddr[11:4]);

    // Raster counters: h wraps at the end of each line and advances v.
    always_comb begin
        hCount_d = hCount_q + 1'b1;
        vCount_d = vCount_q;
        if (hCount_q == H_LAST) begin
            hCount_d = '0;
            vCount_d = vNext;
        end
    end

    // Fetch-ahead address: next group within the line, or word 0 of the next
    // line on the last clk of a line; reset always re-fetches word 0 of line 0.
    always_comb begin
        rdAddr = '0;
        if (!reset) begin
            if (hCount_q == H_LAST) begin
                if (vNext < V_ACT) begin
                    rdAddr = wordAddr(12'(vNext), 8'd0);
                end
            end else if (lineActive && (hCount_q < H_LAST_FETCH) &&
                         (hCount_q[3:0] == 4'hF)) begin
                rdAddr = wordAddr(12'(vCount_q), 8'(hCount_q >> 4) + 8'd1);
            end
        end
    end

    // Framebuffer: synchronous write and registered read returning the old word on collisions.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            fbMem[wrAddr] <= in_bits;
        end
        ramRd_q <= fbMem[rdAddr];
    end

    // Pixel selection and next values of the four aligned outputs.
    always_comb begin
        pixWord   = (hCount_q[3:0] == 4'h0) ? ramRd_q : curWord_q;
        pixBit    = pixWord[~hCount_q[3:0]];
        curWord_d = pixWord;
        armed_d   = armed_q | in_vsync;
        active_d  = inActive;
        video_d   = 1'b0;
        if (inActive) begin
            video_d = armed_q ? (pixBit ^ INVERT) : INVERT;
        end
        hsyncN_d = !(({1'b0, hCount_q} >= HS_BEGIN) && ({1'b0, hCount_q} < HS_END));
        vsyncN_d = !(({1'b0, vCount_q} >= VS_BEGIN) && ({1'b0, vCount_q} < VS_END));
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            hCount_q  <= '0;
            vCount_q  <= '0;
            armed_q   <= 1'b0;
            curWord_q <= '0;
            video_q   <= 1'b0;
            hsyncN_q  <= 1'b1;
            vsyncN_q  <= 1'b1;
            active_q  <= 1'b0;
        end else begin
            hCount_q  <= hCount_d;
            vCount_q  <= vCount_d;
            armed_q   <= armed_d;
            curWord_q <= curWord_d;
            video_q   <= video_d;
            hsyncN_q  <= hsyncN_d;
            vsyncN_q  <= vsyncN_d;
            active_q  <= active_d;
        end
    end

    assign video   = video_q;
    assign hsync_n = hsyncN_q;
    assign vsync_n = vsyncN_q;
    assign active  = active_q;

endmodule
